wb_arb_mux_n: RTL and testbench

Parametrised N-master to one-slave Wishbone arbiter and multiplexer. It is the successor to the fixed two-master priority mux in front of the LM32 instruction and data buses.
- Generalised master count and bus widths.
- Selectable fixed-priority or round-robin arbitration.
- Grant held for a whole bus cycle (CYC-locked).
It sits between lm32_top-style masters (CPU I/D, DMA, debug) and the system Wishbone fabric.

---
 rtl/wb_arb_pkg.sv | 23 ++
 rtl/wb_arb_mux_n_pick.sv | 38 +++
 rtl/wb_arb_mux_n.sv | 156 +++++++++++++++
 tb/tb_wb_arb_mux_n.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the N-master Wishbone arbiter/mux.
package wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Index vectors need at least one bit even for a single master.
  function automatic int idx_w(input int n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arb_mux_n_pick.sv
// Combinational winner picker: lowest index, or first requester at/after ptr
// with wrap-around when ARB_RR is set.
module wb_arb_pick #(
  parameter int NUM_MASTERS = 4,
  parameter int ARB_RR      = 0,
  parameter int GRANT_W     = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [GRANT_W-1:0]     ptr,
  output logic [GRANT_W-1:0]     win,
  output logic                   valid
);

  logic [GRANT_W-1:0]       start;
  logic [2*NUM_MASTERS-1:0] dbl;
  logic [NUM_MASTERS-1:0]   rot;
  int                       pos;
  int                       sum;

  always_comb begin
    start = (ARB_RR != 0) ? ptr : '0;
    // Rotating a doubled copy puts the search origin at bit 0.
    dbl   = {req, req} >> start;
    rot   = dbl[NUM_MASTERS-1:0];
    valid = 1'b0;
    pos   = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        pos   = i;
      end
    end
    sum = int'(start) + pos;
    if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
    win = GRANT_W'(sum);
  end

endmodule

// File: rtl/wb_arb_mux_n.sv
// N-master to one-slave Wishbone arbiter/mux with a CYC-locked grant.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | bus free; winner of c_cyc registered into grant this edge
// OWN   | bus routed to grant until its c_cyc drops
module wb_arb_mux_n
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int ARB_RR         = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            sys_clk,
  input  logic                            resetcpu,
  input  logic [NUM_MASTERS-1:0]          c_cyc,
  input  logic [NUM_MASTERS-1:0]          c_stb,
  input  logic [NUM_MASTERS-1:0]          c_we,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] c_sel,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   c_adr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   c_dat_o,
  output logic [DATA_W-1:0]               c_dat_i,
  output logic [NUM_MASTERS-1:0]          c_ack,
  output logic [NUM_MASTERS-1:0]          c_err,
  output logic                            m_cyc,
  output logic                            m_stb,
  output logic                            m_we,
  output logic [DATA_W/8-1:0]             m_sel,
  output logic [ADDR_W-1:0]               m_adr,
  output logic [DATA_W-1:0]               m_dat_o,
  input  logic [DATA_W-1:0]               m_dat_i,
  input  logic                            m_ack
);

  localparam int SEL_W   = DATA_W / 8;
  localparam int GRANT_W = idx_w(NUM_MASTERS);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic [GRANT_W-1:0] pick_win;
  logic               pick_valid;
  logic               g_cyc;
  logic               g_stb;
  logic               tmo_err;

  wb_arb_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .ARB_RR      (ARB_RR),
    .GRANT_W     (GRANT_W)
  ) u_pick (
    .req   (c_cyc),
    .ptr   (ptr_q),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        g_cyc = c_cyc[i];
        g_stb = c_stb[i];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (resetcpu) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWN;
          grant_d = pick_win;
          ptr_d   = (pick_win == GRANT_W'(NUM_MASTERS - 1)) ? '0 : pick_win + 1'b1;
        end
      end
      OWN: begin
        // Release always passes through IDLE: one dead cycle between owners.
        if (!g_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    m_sel   = '0;
    m_adr   = '0;
    m_dat_o = '0;
    c_ack   = '0;
    c_err   = '0;
    if (state_q == OWN) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (grant_q == GRANT_W'(i)) begin
          m_cyc    = c_cyc[i];
          m_stb    = c_stb[i] & ~tmo_err;
          m_we     = c_we[i];
          m_sel    = c_sel[i*SEL_W +: SEL_W];
          m_adr    = c_adr[i*ADDR_W +: ADDR_W];
          m_dat_o  = c_dat_o[i*DATA_W +: DATA_W];
          c_ack[i] = m_ack & c_stb[i] & ~tmo_err;
          c_err[i] = tmo_err;
        end
      end
    end
  end

  assign c_dat_i = m_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TMO_W = clog2(TIMEOUT_CYCLES + 1);

  // Down-counter loaded with the limit; terminal count 0 is the timeout.
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_err = (state_q == OWN) && g_stb && (tmo_q == '0);

  always_comb begin
    tmo_d = tmo_q;
    if ((state_q != OWN) || m_ack || tmo_err) begin
      tmo_d = TMO_W'(TIMEOUT_CYCLES);
    end else if (g_stb) begin
      tmo_d = tmo_q - 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (resetcpu) tmo_q <= TMO_W'(TIMEOUT_CYCLES);
    else          tmo_q <= tmo_d;
  end
`else
  // No watchdog: a stalled slave holds the bus indefinitely.
  assign tmo_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_wb_arb_mux_n.sv
// Self-checking bench for wb_arb_mux_n: one fixed-priority and one round-robin
// instance sharing stimulus; honours WB_ARB_TIMEOUT_EN when defined.
module tb_wb_arb_mux_n;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            resetcpu;
  logic [N-1:0]    c_cyc, c_stb, c_we;
  logic [N*SW-1:0] c_sel;
  logic [N*AW-1:0] c_adr;
  logic [N*DW-1:0] c_dat_o;
  logic [DW-1:0]   m_dat_i;
  logic            m_ack;

  logic [DW-1:0] fp_c_dat_i, rr_c_dat_i;
  logic [N-1:0]  fp_c_ack, rr_c_ack, fp_c_err, rr_c_err;
  logic          fp_m_cyc, fp_m_stb, fp_m_we, rr_m_cyc, rr_m_stb, rr_m_we;
  logic [SW-1:0] fp_m_sel, rr_m_sel;
  logic [AW-1:0] fp_m_adr, rr_m_adr;
  logic [DW-1:0] fp_m_dat_o, rr_m_dat_o;

  always #5 clk = ~clk;

  wb_arb_mux_n #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_RR(0), .TIMEOUT_CYCLES(8)) dut_fp (
    .sys_clk(clk), .resetcpu(resetcpu), .c_cyc(c_cyc), .c_stb(c_stb), .c_we(c_we),
    .c_sel(c_sel), .c_adr(c_adr), .c_dat_o(c_dat_o), .c_dat_i(fp_c_dat_i),
    .c_ack(fp_c_ack), .c_err(fp_c_err), .m_cyc(fp_m_cyc), .m_stb(fp_m_stb),
    .m_we(fp_m_we), .m_sel(fp_m_sel), .m_adr(fp_m_adr), .m_dat_o(fp_m_dat_o),
    .m_dat_i(m_dat_i), .m_ack(m_ack));

  wb_arb_mux_n #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_RR(1), .TIMEOUT_CYCLES(8)) dut_rr (
    .sys_clk(clk), .resetcpu(resetcpu), .c_cyc(c_cyc), .c_stb(c_stb), .c_we(c_we),
    .c_sel(c_sel), .c_adr(c_adr), .c_dat_o(c_dat_o), .c_dat_i(rr_c_dat_i),
    .c_ack(rr_c_ack), .c_err(rr_c_err), .m_cyc(rr_m_cyc), .m_stb(rr_m_stb),
    .m_we(rr_m_we), .m_sel(rr_m_sel), .m_adr(rr_m_adr), .m_dat_o(rr_m_dat_o),
    .m_dat_i(m_dat_i), .m_ack(m_ack));

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] we_pat = 4'b0101;

  typedef struct {
    logic [N-1:0] cyc;
    logic [N-1:0] stb;
    logic         ack;
    int           g;      // 7 = nothing routed (IDLE)
    logic         mcyc;
    logic         mstb;
    logic [N-1:0] cack;
  } vec_t;

  vec_t        tbl[13];
  logic [31:0] dat_q[$];
  int          ord_q[$];

  function automatic logic [AW-1:0] adr_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h10;
  endfunction

  function automatic logic [DW-1:0] dat_of(input int i);
    return 32'hD000_0000 + 32'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] cyc, input logic [N-1:0] stb, input logic ack);
    c_cyc = cyc;
    c_stb = stb;
    m_ack = ack;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int            grants;
    logic [N-1:0]  req;
    logic [DW-1:0] exp_dat;
    int            err_at;
    int            extra;

    for (int i = 0; i < N; i++) begin
      c_adr[i*AW +: AW]   = adr_of(i);
      c_dat_o[i*DW +: DW] = dat_of(i);
      c_sel[i*SW +: SW]   = SW'(i + 1);
    end
    c_we     = we_pat;
    m_dat_i  = 32'h1234_5678;

    //            cyc      stb      ack  g  mcyc  mstb  cack
    tbl[0]  = '{4'b1010, 4'b1010, 1'b0, 7, 1'b0, 1'b0, 4'b0000};
    tbl[1]  = '{4'b1010, 4'b1010, 1'b0, 1, 1'b1, 1'b1, 4'b0000};
    tbl[2]  = '{4'b1010, 4'b1010, 1'b1, 1, 1'b1, 1'b1, 4'b0010};
    tbl[3]  = '{4'b1000, 4'b1000, 1'b0, 1, 1'b0, 1'b0, 4'b0000};
    tbl[4]  = '{4'b1000, 4'b1000, 1'b0, 7, 1'b0, 1'b0, 4'b0000};
    tbl[5]  = '{4'b1000, 4'b1000, 1'b0, 3, 1'b1, 1'b1, 4'b0000};
    tbl[6]  = '{4'b1000, 4'b1000, 1'b1, 3, 1'b1, 1'b1, 4'b1000};
    tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 3, 1'b0, 1'b0, 4'b0000};
    tbl[8]  = '{4'b0100, 4'b0100, 1'b0, 7, 1'b0, 1'b0, 4'b0000};
    tbl[9]  = '{4'b0100, 4'b0000, 1'b1, 2, 1'b1, 1'b0, 4'b0000};
    tbl[10] = '{4'b0100, 4'b0100, 1'b0, 2, 1'b1, 1'b1, 4'b0000};
    tbl[11] = '{4'b0000, 4'b0000, 1'b0, 2, 1'b0, 1'b0, 4'b0000};
    tbl[12] = '{4'b0000, 4'b0000, 1'b1, 7, 1'b0, 1'b0, 4'b0000};

    // Reset with every master requesting and the slave acking.
    resetcpu = 1'b1;
    drive(4'b1111, 4'b1111, 1'b1);
    tick();
    tick();
    chk("rst_m_cyc", fp_m_cyc, 0);
    chk("rst_m_stb", fp_m_stb, 0);
    chk("rst_m_we", fp_m_we, 0);
    chk("rst_c_ack", fp_c_ack, 0);
    chk("rst_c_err", fp_c_err, 0);
    chk("rst_m_adr", fp_m_adr, 0);
    chk("rst_m_sel", fp_m_sel, 0);
    chk("rst_m_dat_o", fp_m_dat_o, 0);
    chk("rst_rr_m_cyc", rr_m_cyc, 0);
    chk("rst_rr_c_ack", rr_c_ack, 0);
    resetcpu = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0);

    // Fixed priority, dead cycle, ack gating, drop without ack, late ack.
    for (int r = 0; r < 13; r++) begin
      tick();
      drive(tbl[r].cyc, tbl[r].stb, tbl[r].ack);
      #1;
      chk($sformatf("row%0d_m_cyc", r), fp_m_cyc, tbl[r].mcyc);
      chk($sformatf("row%0d_m_stb", r), fp_m_stb, tbl[r].mstb);
      chk($sformatf("row%0d_c_ack", r), fp_c_ack, tbl[r].cack);
      chk($sformatf("row%0d_m_adr", r), fp_m_adr, (tbl[r].g == 7) ? '0 : adr_of(tbl[r].g));
      chk($sformatf("row%0d_m_dat_o", r), fp_m_dat_o, (tbl[r].g == 7) ? '0 : dat_of(tbl[r].g));
      chk($sformatf("row%0d_m_we", r), fp_m_we, (tbl[r].g == 7) ? 1'b0 : we_pat[tbl[r].g]);
    end

    // CYC lock: master 2 bursts 4 beats while master 0 waits.
    tick();
    drive(4'b0100, 4'b0100, 1'b0);
    tick();
    drive(4'b0101, 4'b0101, 1'b0);
    #1;
    chk("lock_m_adr", fp_m_adr, adr_of(2));
    for (int n = 0; n < 4; n++) begin
      tick();
      m_ack   = 1'b1;
      m_dat_i = 32'hA5A5_0000 + 32'(n);
      dat_q.push_back(32'hA5A5_0000 + 32'(n));
      #1;
      exp_dat = dat_q.pop_front();
      chk($sformatf("lock_beat%0d_dat", n), fp_c_dat_i, exp_dat);
      chk($sformatf("lock_beat%0d_ack", n), fp_c_ack, 4'b0100);
    end
    tick();
    drive(4'b0001, 4'b0001, 1'b0);
    #1;
    chk("lock_release_ack", fp_c_ack, 0);
    chk("lock_release_cyc", fp_m_cyc, 0);
    tick();
    chk("lock_dead_cyc", fp_m_cyc, 0);
    tick();
    chk("lock_next_cyc", fp_m_cyc, 1);
    chk("lock_next_adr", fp_m_adr, adr_of(0));

    // Reset mid-cycle while master 2 owns the bus with STB high.
    drive(4'b0000, 4'b0000, 1'b0);
    resetcpu = 1'b1;
    tick();
    resetcpu = 1'b0;
    drive(4'b0100, 4'b0100, 1'b0);
    tick();
    chk("midrst_own_stb", rr_m_stb, 1);
    chk("midrst_own_adr", rr_m_adr, adr_of(2));
    resetcpu = 1'b1;
    m_ack    = 1'b1;
    tick();
    chk("midrst_rr_m_cyc", rr_m_cyc, 0);
    chk("midrst_rr_c_ack", rr_c_ack, 0);
    chk("midrst_fp_m_cyc", fp_m_cyc, 0);
    chk("midrst_fp_c_ack", fp_c_ack, 0);
    resetcpu = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0);

    // Round-robin: all masters keep requesting; order must start at 0.
    ord_q  = '{0, 1, 2, 3, 0};
    grants = 0;
    req    = 4'b1111;
    for (int c = 0; c < 60 && grants < 5; c++) begin
      tick();
      drive(req, req, 1'b0);
      #1;
      if (rr_m_cyc && rr_m_stb) m_ack = 1'b1;
      #1;
      req = 4'b1111;
      if (rr_c_ack != 0) begin
        chk($sformatf("rr_grant%0d", grants), rr_c_ack, 4'b0001 << ord_q.pop_front());
        req    = ~rr_c_ack;
        grants = grants + 1;
      end
    end
    chk("rr_grants_seen", grants, 5);

    tick();
    drive(4'b0000, 4'b0000, 1'b0);
    tick();
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // Stalled slave: one error pulse 8 cycles after STB, STB masked then.
    drive(4'b0010, 4'b0010, 1'b0);
    tick();
    #1;
    chk("tmo_stb_start", fp_m_stb, 1);
    err_at = -1;
    for (int k = 1; k <= 30 && err_at < 0; k++) begin
      tick();
      if (fp_c_err != 0) begin
        err_at = k;
        chk("tmo_err_bit", fp_c_err, 4'b0010);
        chk("tmo_err_stb", fp_m_stb, 0);
        drive(4'b0000, 4'b0000, 1'b0);
      end
    end
    chk("tmo_err_cycle", err_at, 8);
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (fp_c_err != 0) extra++;
    end
    chk("tmo_extra_pulses", extra, 0);
`else
    // No watchdog: a 100-cycle stall never raises ERR or drops STB.
    drive(4'b0010, 4'b0010, 1'b0);
    tick();
    for (int k = 0; k < 100; k++) begin
      tick();
      chk($sformatf("noto_err%0d", k), fp_c_err, 0);
    end
    chk("noto_stb_held", fp_m_stb, 1);
    err_at = 0;
    extra  = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
